// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and the
// field layout of the 9-bit bus-CPU instruction word.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StHalt,
    StFault
  } seq_state_e;

  // Instruction word: [8:6] opcode, [5:3] Rx, [2:0] Ry
  localparam int unsigned OpcodeMsb = 8;
  localparam int unsigned OpcodeLsb = 6;
  localparam int unsigned RxMsb     = 5;
  localparam int unsigned RxLsb     = 3;
  localparam int unsigned RyMsb     = 2;
  localparam int unsigned RyLsb     = 0;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;

  function automatic logic [8:0] make_instr(input logic [2:0] op, input logic [2:0] rx,
                                            input logic [2:0] ry);
    return {op, rx, ry};
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory for the sequencer: one synchronous write port, one synchronous
// read port with a resettable output register (contents themselves are not reset).
module instr_sequencer_prog_mem #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 25
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [W-1:0] mem_q [Depth];
  logic [W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only updates on a fetch, so the CPU sees stable operands.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a loadable program, one entry at a time, into the 16-bit bus CPU and waits
// for done between entries. Define INSTR_SEQ_WATCHDOG_EN to add the WAIT watchdog.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned AW          = 4,
  parameter int unsigned IW          = 9,
  parameter int unsigned DW          = 16,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_instr,
  input  logic [DW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          run,
  input  logic          stop_req,
  input  logic          cpu_done,
  output logic          cpu_start,
  output logic [IW-1:0] cpu_instruction,
  output logic [DW-1:0] cpu_data,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          fault
);

  localparam int unsigned Depth  = 2 ** AW;
  localparam logic [AW:0] MaxLen = (AW + 1)'(Depth);

  seq_state_e           state_d, state_q;
  logic [AW-1:0]        pc_d, pc_q;
  logic [AW:0]          len_d, len_q;
  logic                 stop_d, stop_q;
  logic [AW:0]          len_eff;
  logic                 last_entry;
  logic                 mem_we;
  logic [IW+DW-1:0]     mem_rdata;
  logic                 wdog_hit;

  assign len_eff    = (prog_len > MaxLen) ? MaxLen : prog_len;
  assign last_entry = ({1'b0, pc_q} + (AW + 1)'(1)) == len_q;
  assign mem_we     = load_en && ((state_q == StIdle) || (state_q == StHalt));

  instr_sequencer_prog_mem #(
    .AW (AW),
    .W  (IW + DW)
  ) u_prog_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i ({load_instr, load_data}),
    .re_i    (state_q == StFetch),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

`ifdef INSTR_SEQ_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);

  logic [CntW-1:0] wdog_d, wdog_q;

  // Fires on the last permitted WAIT cycle; a done in that same cycle still wins.
  assign wdog_hit = (state_q == StWait) && !cpu_done && (wdog_q == CntW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if ((state_q == StWait) && (state_d == StWait)) begin
      wdog_d = wdog_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign fault = (state_q == StFault);
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
  assign fault       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    stop_d  = stop_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (run && (len_eff != '0)) begin
          state_d = StFetch;
          pc_d    = '0;
          len_d   = len_eff;
        end
      end
      StFetch: state_d = StIssue;
      StIssue: begin
        state_d = StWait;
        stop_d  = stop_q | stop_req;
      end
      StWait: begin
        stop_d = stop_q | stop_req;
        if (cpu_done) begin
          if (last_entry || stop_d) begin
            state_d = StHalt;
            stop_d  = 1'b0;
          end else begin
            state_d = StFetch;
            pc_d    = pc_q + AW'(1);
          end
        end else if (wdog_hit) begin
          state_d = StFault;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      stop_q  <= stop_d;
    end
  end

  assign cpu_start       = (state_q == StIssue);
  assign busy            = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
  assign halted          = (state_q == StHalt);
  assign pc              = pc_q;
  assign cpu_instruction = mem_rdata[IW+DW-1:DW];
  assign cpu_data        = mem_rdata[DW-1:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected issues, a monitor
// pops them on every cpu_start. Define INSTR_SEQ_WATCHDOG_EN to also test the watchdog.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  typedef struct {
    logic [8:0]  instr;
    logic [15:0] data;
    logic [3:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [8:0]  load_instr;
  logic [15:0] load_data;
  logic [4:0]  prog_len;
  logic        run;
  logic        stop_req;
  logic        cpu_done;
  logic        cpu_start;
  logic [8:0]  cpu_instruction;
  logic [15:0] cpu_data;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        fault;

  exp_t exp_q[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   n_starts  = 0;
  bit   cpu_auto  = 1'b1;
  bit   force_done = 1'b0;

  instr_sequencer #(
    .AW          (4),
    .IW          (9),
    .DW          (16),
    .WDOG_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_instr      (load_instr),
    .load_data       (load_data),
    .prog_len        (prog_len),
    .run             (run),
    .stop_req        (stop_req),
    .cpu_done        (cpu_done),
    .cpu_start       (cpu_start),
    .cpu_instruction (cpu_instruction),
    .cpu_data        (cpu_data),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] i, input logic [15:0] d, input logic [3:0] p);
    exp_t e;
    e.instr = i;
    e.data  = d;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [3:0] a, input logic [8:0] i, input logic [15:0] d);
    @(negedge clk);
    load_en    = 1'b1;
    load_addr  = a;
    load_instr = i;
    load_data  = d;
    @(negedge clk);
    load_en    = 1'b0;
  endtask

  task automatic run_pulse();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_start) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no cpu_start within 50 cycles, expected one", name);
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (halted) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: halted=0 after 200 cycles, expected 1", name);
  endtask

  // CPU model: done pulses for one cycle, three cycles after the start cycle.
  initial begin
    int cnt;
    cnt      = 0;
    cpu_done = 1'b0;
    forever begin
      @(negedge clk);
      cpu_done = force_done;
      if (rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) cpu_done = 1'b1;
      end
      if (cpu_start && cpu_auto && !rst) cnt = 3;
    end
  end

  // Monitor: every start must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_start === 1'b1) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: got start with instr %0h data %0h pc %0h, expected none",
                   cpu_instruction, cpu_data, pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_instr", 32'(cpu_instruction), 32'(e.instr));
          chk("issue_data", 32'(cpu_data), 32'(e.data));
          chk("issue_pc", 32'(pc), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst        = 1'b1;
    load_en    = 1'b0;
    load_addr  = '0;
    load_instr = '0;
    load_data  = '0;
    prog_len   = '0;
    run        = 1'b0;
    stop_req   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start", 32'(cpu_start), 0);
    chk("rst_instr", 32'(cpu_instruction), 0);
    chk("rst_data", 32'(cpu_data), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);

    // Two-entry program
    load(4'd0, 9'b001_000_000, 16'h00A5);
    load(4'd1, 9'b000_001_000, 16'h0000);
    prog_len = 5'd2;
    push(9'b001_000_000, 16'h00A5, 4'd0);
    push(9'b000_001_000, 16'h0000, 4'd1);
    base = n_starts;
    run_pulse();
    wait_start("single_first_start");
    @(negedge clk);
    chk("wait_start_low", 32'(cpu_start), 0);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_data_held", 32'(cpu_data), 32'h00A5);
    wait_halt("single_halt");
    chk("single_halted", 32'(halted), 1);
    chk("single_pc", 32'(pc), 1);
    chk("single_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("single_starts", 32'(n_starts - base), 2);

    // Load during WAIT must be dropped; the rerun still sees the original entry 0
    push(9'b001_000_000, 16'h00A5, 4'd0);
    push(9'b000_001_000, 16'h0000, 4'd1);
    run_pulse();
    wait_start("busy_load_start");
    @(negedge clk);
    load_en    = 1'b1;
    load_addr  = 4'd0;
    load_instr = 9'h1FF;
    load_data  = 16'hFFFF;
    @(negedge clk);
    load_en = 1'b0;
    wait_halt("busy_load_halt");
    push(9'b001_000_000, 16'h00A5, 4'd0);
    push(9'b000_001_000, 16'h0000, 4'd1);
    base = n_starts;
    run_pulse();
    wait_halt("rerun_halt");
    repeat (3) @(negedge clk);
    chk("rerun_starts", 32'(n_starts - base), 2);

    // Reset in the middle of WAIT
    push(9'b001_000_000, 16'h00A5, 4'd0);
    run_pulse();
    wait_start("rst_mid_start");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_start", 32'(cpu_start), 0);
    chk("midrst_instr", 32'(cpu_instruction), 0);
    chk("midrst_data", 32'(cpu_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_halted", 32'(halted), 0);
    chk("midrst_pc", 32'(pc), 0);
    rst  = 1'b0;
    base = n_starts;
    repeat (10) @(negedge clk);
    chk("midrst_no_start", 32'(n_starts - base), 0);

    // Zero-length program never leaves IDLE
    prog_len = 5'd0;
    run      = 1'b1;
    repeat (10) @(negedge clk);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_halted", 32'(halted), 0);
    chk("len0_no_start", 32'(n_starts - base), 0);
    run = 1'b0;

    // stop_req during entry 1 of a four-entry program
    load(4'd0, make_instr(OpMvi, 3'd2, 3'd0), 16'h1111);
    load(4'd1, make_instr(OpAdd, 3'd0, 3'd1), 16'h2222);
    load(4'd2, make_instr(OpSub, 3'd1, 3'd2), 16'h3333);
    load(4'd3, make_instr(OpMv, 3'd3, 3'd0), 16'h4444);
    prog_len = 5'd4;
    push(9'b001_010_000, 16'h1111, 4'd0);
    push(9'b010_000_001, 16'h2222, 4'd1);
    base = n_starts;
    run_pulse();
    wait_start("stop_entry0");
    wait_start("stop_entry1");
    @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    wait_halt("stop_halt");
    chk("stop_pc", 32'(pc), 1);
    repeat (15) @(negedge clk);
    chk("stop_halted_stays", 32'(halted), 1);
    chk("stop_starts", 32'(n_starts - base), 2);

`ifdef INSTR_SEQ_WATCHDOG_EN
    // Watchdog: done never arrives
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    cpu_auto = 1'b0;
    prog_len = 5'd1;
    push(9'b001_010_000, 16'h1111, 4'd0);
    run_pulse();
    wait_start("wdog_start");
    repeat (8) @(negedge clk);
    chk("wdog_wait8_fault", 32'(fault), 0);
    @(negedge clk);
    chk("wdog_fault", 32'(fault), 1);
    chk("wdog_busy", 32'(busy), 0);
    force_done = 1'b1;
    run        = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b0;
    chk("wdog_fault_sticky", 32'(fault), 1);
    chk("wdog_start_low", 32'(cpu_start), 0);
    chk("wdog_data_held", 32'(cpu_data), 32'h1111);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the 16-bit bus CPU.
- Holds a small loadable program memory; each entry is a 9-bit instruction plus a 16-bit immediate word.
- Issues entries one at a time on the CPU's start/instruction/data_var inputs and waits for the CPU's done before advancing.
- Provides run/stop control, a program counter and status flags to the top level.

Parameters:
- AW, 4, program memory address width (depth = 2**AW entries).
- IW, 9, instruction width (matches CPU instruction input).
- DW, 16, immediate/data width (matches CPU data_var).
- WDOG_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_en  in  1  write program memory this cycle
- load_addr  in  AW  write address
- load_instr  in  IW  instruction to store
- load_data  in  DW  immediate to store
- prog_len  in  AW+1  number of valid entries, 0..2**AW
- run  in  1  start execution from pc=0 (level sampled per cycle)
- stop_req  in  1  finish current instruction, then halt
- cpu_done  in  1  done from CPU
- cpu_start  out  1  start to CPU
- cpu_instruction  out  IW  instruction to CPU
- cpu_data  out  DW  data_var to CPU
- pc  out  AW  index of current entry
- busy  out  1  executing (FETCH/ISSUE/WAIT)
- halted  out  1  program completed or stopped
- fault  out  1  watchdog fault (optional feature)

Behaviour:
- Reset (async, active-high) sets:
  - pc=0, cpu_start=0, cpu_instruction=0, cpu_data=0.
  - busy=0, halted=0, fault=0, state=IDLE.
  - Memory contents are not reset.
- Memory: 2**AW x (IW+DW), synchronous write, synchronous read (1-cycle latency).
- Loading:
  - load_en is honoured only in IDLE or HALT.
  - In FETCH/ISSUE/WAIT the write is dropped silently.
- FSM states and transitions:
  - IDLE: run=1 and prog_len!=0 -> FETCH with pc=0. Otherwise stay.
  - FETCH (1 cycle): read address pc. Next cycle cpu_instruction/cpu_data register the read data -> ISSUE.
  - ISSUE (1 cycle): cpu_start=1 -> WAIT.
  - WAIT: cpu_start=0; cpu_instruction/cpu_data held stable. When cpu_done=1:
    - pc==prog_len-1, or stop_req=1 seen since ISSUE -> HALT, halted=1.
    - otherwise pc<=pc+1 -> FETCH.
  - HALT: cpu_start=0, halted=1, pc frozen. run=1 -> clear halted, pc=0 -> FETCH (requires prog_len!=0).
- cpu_done is sampled only in WAIT. done during ISSUE or FETCH is ignored.
- Per-instruction latency: FETCH + ISSUE + CPU cycles. The minimum gap from done to the next start is 2 cycles.
- stop_req is latched (sticky) from ISSUE onward and cleared on entry to HALT. It never aborts an instruction in flight.
- prog_len is sampled at the run edge into an internal register. Changes during execution are ignored.
- prog_len > 2**AW is treated as 2**AW.
- pc never wraps: the last entry always leads to HALT.
- run held high continuously: after HALT the program restarts, so the block loops the program.
- busy=1 in FETCH/ISSUE/WAIT, else 0.
- Reset mid-operation: immediate return to reset values. The CPU is reset by the same rst.

Optional Feature:
- Macro: INSTR_SEQ_WATCHDOG_EN.
- With the macro:
  - A cycle counter runs in WAIT and clears on each state entry.
  - If it reaches WDOG_CYCLES without cpu_done -> FAULT state.
  - In FAULT: fault=1, busy=0, cpu_start=0, outputs held.
  - FAULT exits only on rst. run is ignored in FAULT.
- Without the macro:
  - No counter and no FAULT state.
  - fault is tied 0.
  - WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, FETCH, ISSUE, WAIT, HALT, FAULT);
  - the opcode field constants for the 9-bit instruction (bits [8:6] opcode, [5:3] Rx, [2:0] Ry) used by the CPU control circuit and the bench.
- One sub-module is natural: prog_mem (synchronous 1W/1R memory, width IW+DW, depth 2**AW).

Test Plan:
- Reset: assert rst mid-WAIT -> next cycle all outputs 0, state IDLE; release rst, run=0 -> cpu_start stays 0.
- Single program:
  - Stimulus: load [0]=9'b001_000_000/16'h00A5, [1]=9'b000_001_000/16'h0000; prog_len=2; pulse run; model done 3 cycles after each start.
  - Response: two cpu_start pulses, first with cpu_data=16'h00A5, then halted=1 with pc=1.
- Load during busy: load_en to addr 0 while in WAIT -> memory unchanged, verified by rerun.
- prog_len=0 with run=1 -> stays IDLE, busy=0, no start.
- stop_req pulsed during entry 1 of a 4-entry program -> entry 1 completes, halted=1, pc=1, no further start.
- Watchdog (macro on), WDOG_CYCLES=8: never assert done -> fault=1 on the 8th WAIT cycle; done asserted afterwards does not clear it.
